// File: rtl/logic_unit_pipe.sv
// Single-stage bitwise logic unit with a sticky accumulator and a one-deep
// valid/ready output register; counts completed output transfers.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic [CNT_W-1:0] xfer_cnt
);

   localparam logic [2:0] OP_AND     = 3'b000;
   localparam logic [2:0] OP_OR      = 3'b001;
   localparam logic [2:0] OP_XOR     = 3'b010;
   localparam logic [2:0] OP_NAND    = 3'b011;
   localparam logic [2:0] OP_NOR     = 3'b100;
   localparam logic [2:0] OP_XNOR    = 3'b101;
   localparam logic [2:0] OP_ACC_AND = 3'b110;
   localparam logic [2:0] OP_ACC_OR  = 3'b111;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             acc_empty_q, acc_empty_d;

   logic             in_xfer;
   logic             out_xfer;
   logic             is_acc_op;
   logic [WIDTH-1:0] acc_eff;
   logic             empty_eff;
   logic [WIDTH-1:0] res;

   assign in_ready  = !valid_q || out_ready;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = valid_q && out_ready;
   assign is_acc_op = (op == OP_ACC_AND) || (op == OP_ACC_OR);

   // A same-cycle clear is applied before the accumulate so the operand reloads acc.
   assign acc_eff   = acc_clr ? '0 : acc_q;
   assign empty_eff = acc_clr || acc_empty_q;

   always_comb begin
      res = '0;
      unique case (op)
         OP_AND:     res = a & b;
         OP_OR:      res = a | b;
         OP_XOR:     res = a ^ b;
         OP_NAND:    res = ~(a & b);
         OP_NOR:     res = ~(a | b);
         OP_XNOR:    res = ~(a ^ b);
         OP_ACC_AND: res = empty_eff ? a : (acc_eff & a);
         OP_ACC_OR:  res = empty_eff ? a : (acc_eff | a);
         default:    res = '0;
      endcase
   end

   always_comb begin
      valid_d     = valid_q;
      y_d         = y_q;
      zero_d      = zero_q;
      cnt_d       = cnt_q;
      acc_d       = acc_eff;
      acc_empty_d = empty_eff;

      if (out_xfer) begin
         valid_d = 1'b0;
         cnt_d   = cnt_q + 1'b1;
      end
      if (in_xfer) begin
         valid_d = 1'b1;
         y_d     = res;
         zero_d  = (res == '0);
         if (is_acc_op) begin
            acc_d       = res;
            acc_empty_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         y_q         <= '0;
         zero_q      <= 1'b1;
         cnt_q       <= '0;
         acc_q       <= '0;
         acc_empty_q <= 1'b1;
      end else begin
         valid_q     <= valid_d;
         y_q         <= y_d;
         zero_q      <= zero_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         acc_empty_q <= acc_empty_d;
      end
   end

   assign out_valid = valid_q;
   assign y         = y_q;
   assign zero      = zero_q;
   assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=8, CNT_W=4 so the counter wrap
// is reachable in a short run).
module tb_logic_unit_pipe;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       acc_clr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
   logic       zero;
   logic [3:0] xfer_cnt;

   logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .zero      (zero),
      .xfer_cnt  (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed;
   int total;

   // Reference model state
   logic       mv;
   logic [3:0] mcnt;
   logic [7:0] macc;
   logic       memp;
   logic [8:0] sb[$];    // {zero, y} expected, in order
   logic [8:0] pops[$];  // results consumed by the bench, in order

   logic [7:0] tt_exp [6];
   logic [7:0] acc_exp [5];

   task automatic step(input logic iv, input logic [2:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic clr, input logic ordy);
      logic       exp_ir, in_x, out_x, eemp;
      logic [7:0] eacc, r;
      logic [8:0] head;
      in_valid = iv; op = o; a = av; b = bv; acc_clr = clr; out_ready = ordy;
      #1;
      exp_ir = !mv || ordy;
      total++;
      if (in_ready !== exp_ir)
         $display("FAIL in_ready: got %b want %b", in_ready, exp_ir);
      else passed++;
      if (mv) begin
         total++;
         if (sb.size() == 0) begin
            $display("FAIL scoreboard: out_valid expected but queue empty");
         end else begin
            head = sb[0];
            if (y !== head[7:0] || zero !== head[8])
               $display("FAIL result: got y=%h zero=%b want y=%h zero=%b", y, zero, head[7:0], head[8]);
            else passed++;
            if (ordy) pops.push_back(sb.pop_front());
         end
      end
      total++;
      if (xfer_cnt !== mcnt)
         $display("FAIL xfer_cnt: got %0d want %0d", xfer_cnt, mcnt);
      else passed++;

      in_x  = iv && exp_ir;
      out_x = mv && ordy;
      eacc  = clr ? 8'h00 : macc;
      eemp  = clr | memp;
      case (o)
         3'd0: r = av & bv;
         3'd1: r = av | bv;
         3'd2: r = av ^ bv;
         3'd3: r = ~(av & bv);
         3'd4: r = ~(av | bv);
         3'd5: r = ~(av ^ bv);
         3'd6: r = eemp ? av : (eacc & av);
         default: r = eemp ? av : (eacc | av);
      endcase
      macc = eacc;
      memp = eemp;
      if (in_x) begin
         sb.push_back({(r == 8'h00), r});
         if (o[2] && o[1]) begin
            macc = r;
            memp = 1'b0;
         end
      end
      if (out_x) mcnt = mcnt + 4'd1;
      mv = in_x ? 1'b1 : (out_x ? 1'b0 : mv);

      @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== mv)
         $display("FAIL out_valid: got %b want %b", out_valid, mv);
      else passed++;
   endtask

   task automatic drain();
      for (int i = 0; i < 4 && mv; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic check_reset_state();
      out_ready = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || y !== 8'h00 || zero !== 1'b1 || xfer_cnt !== 4'd0 || in_ready !== 1'b1)
         $display("FAIL reset_state: got v=%b y=%h z=%b cnt=%0d ir=%b want v=0 y=00 z=1 cnt=0 ir=1",
                  out_valid, y, zero, xfer_cnt, in_ready);
      else passed++;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b1; op = 3'd6; a = 8'h77; b = 8'h11; acc_clr = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mv = 1'b0; mcnt = 4'd0; macc = 8'h00; memp = 1'b1;
      sb.delete();
      pops.delete();
   endtask

   task automatic test_reset();
      do_reset();
      check_reset_state();
   endtask

   task automatic test_truth_table();
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 3'(i), 8'hF0, 8'hCC, 1'b0, 1'b1);
      drain();
      total++;
      if (pops.size() != 6) $display("FAIL tt_count: got %0d results want 6", pops.size());
      else passed++;
      for (int i = 0; i < 6 && i < pops.size(); i++) begin
         total++;
         if (pops[i][7:0] !== tt_exp[i]) $display("FAIL tt_op%0d: got %h want %h", i, pops[i][7:0], tt_exp[i]);
         else passed++;
      end
      total++;
      if (xfer_cnt !== 4'd6) $display("FAIL tt_xfer_cnt: got %0d want 6", xfer_cnt);
      else passed++;
   endtask

   task automatic test_accumulate();
      do_reset();
      step(1'b1, 3'd6, 8'hFF, 8'h00, 1'b0, 1'b1);
      step(1'b1, 3'd6, 8'h0F, 8'hAA, 1'b0, 1'b1);
      step(1'b1, 3'd2, 8'h12, 8'h34, 1'b0, 1'b1);  // non-accumulate op leaves acc alone
      step(1'b1, 3'd6, 8'h3C, 8'h55, 1'b0, 1'b1);
      step(1'b1, 3'd7, 8'h01, 8'h00, 1'b1, 1'b1);
      step(1'b1, 3'd7, 8'h80, 8'h00, 1'b0, 1'b1);
      drain();
      void'(pops.delete(2));
      total++;
      if (pops.size() != 5) $display("FAIL acc_count: got %0d results want 5", pops.size());
      else passed++;
      for (int i = 0; i < 5 && i < pops.size(); i++) begin
         total++;
         if (pops[i][7:0] !== acc_exp[i]) $display("FAIL acc_%0d: got %h want %h", i, pops[i][7:0], acc_exp[i]);
         else passed++;
      end
   endtask

   task automatic test_zero_flag();
      do_reset();
      step(1'b1, 3'd0, 8'hAA, 8'h55, 1'b0, 1'b1);
      step(1'b1, 3'd1, 8'hAA, 8'h55, 1'b0, 1'b1);
      drain();
      total++;
      if (pops.size() != 2 || pops[0] !== 9'h100 || pops[1] !== 9'h0FF)
         $display("FAIL zero_flag: got %0d results, first=%h second=%h want 100 0ff",
                  pops.size(), pops.size() > 0 ? pops[0] : 9'h0, pops.size() > 1 ? pops[1] : 9'h0);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [3:0] cnt_before;
      do_reset();
      step(1'b1, 3'd2, 8'h01, 8'h10, 1'b0, 1'b1);
      cnt_before = xfer_cnt;
      for (int i = 0; i < 3; i++) step(1'b1, 3'(i), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      total++;
      if (xfer_cnt !== cnt_before || y !== 8'h11)
         $display("FAIL stall_hold: got cnt=%0d y=%h want cnt=%0d y=11", xfer_cnt, y, cnt_before);
      else passed++;
      for (int i = 0; i < 8; i++) step(1'b1, 3'(i % 6), 8'(i * 17 + 3), 8'(i * 29 + 5), 1'b0, 1'b1);
      drain();
      total++;
      if (pops.size() != 9 || sb.size() != 0)
         $display("FAIL bp_count: got %0d results, %0d left want 9, 0", pops.size(), sb.size());
      else passed++;
   endtask

   task automatic test_back_to_back_random();
      do_reset();
      for (int i = 0; i < 60; i++)
         step($urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
      drain();
      total++;
      if (sb.size() != 0) $display("FAIL random_drain: got %0d left want 0", sb.size());
      else passed++;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) step(1'b1, 3'd1, 8'(i), 8'h00, 1'b0, 1'b1);
      drain();
      total++;
      if (xfer_cnt !== 4'd1) $display("FAIL wrap: got %0d want 1", xfer_cnt);
      else passed++;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      step(1'b1, 3'd6, 8'h33, 8'h00, 1'b0, 1'b1);
      step(1'b1, 3'd0, 8'hF0, 8'hFF, 1'b0, 1'b0);
      step(1'b1, 3'd1, 8'h0F, 8'h00, 1'b0, 1'b0);
      do_reset();
      check_reset_state();
      step(1'b1, 3'd6, 8'h5A, 8'h00, 1'b0, 1'b1);
      drain();
      total++;
      if (pops.size() != 1 || pops[0] !== 9'h05A)
         $display("FAIL rst_stall_acc: got %0d results first=%h want 1 05a",
                  pops.size(), pops.size() > 0 ? pops[0] : 9'h0);
      else passed++;
   endtask

   initial begin
      passed = 0; total = 0;
      tt_exp  = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3};
      acc_exp = '{8'hFF, 8'h0F, 8'h0C, 8'h01, 8'h81};
      rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; acc_clr = 1'b0; out_ready = 1'b0;
      mv = 1'b0; mcnt = 4'd0; macc = 8'h00; memp = 1'b1;
      @(negedge clk);
      test_reset();
      test_truth_table();
      test_accumulate();
      test_zero_flag();
      test_backpressure();
      test_back_to_back_random();
      test_wrap();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
